// File: rtl/aes_key_sched_ctrl_if.sv
// aes_key_sched_ctrl_if: key-load and round-key stream bundle for aes_key_sched_ctrl.
// Optional macro AES_KEY_STORE_EN adds the key-store read port (rd_addr, rd_key, store_valid).
//
// Handshake: a round-key beat transfers on a rising clk edge where rk_valid && rk_ready.
// While rk_valid is high and rk_ready is low, rk_out and rk_round hold stable; rk_valid
// never drops without a transfer except on rst.
interface aes_key_sched_ctrl_if;
    logic           start;
    logic [0:127]   key_in;
    logic           busy;
    logic           rk_valid;
    logic           rk_ready;
    logic [0:3]     rk_round;
    logic [0:127]   rk_out;
    logic           done;
`ifdef AES_KEY_STORE_EN
    logic [0:3]     rd_addr;
    logic [0:127]   rd_key;
    logic           store_valid;
`endif

    // Key-schedule controller side
    modport slave (
        input  start, key_in, rk_ready,
        output busy, rk_valid, rk_round, rk_out, done
`ifdef AES_KEY_STORE_EN
        ,
        input  rd_addr,
        output rd_key, store_valid
`endif
    );

    // Key loader / round datapath side
    modport master (
        output start, key_in, rk_ready,
        input  busy, rk_valid, rk_round, rk_out, done
`ifdef AES_KEY_STORE_EN
        ,
        output rd_addr,
        input  rd_key, store_valid
`endif
    );
endinterface

// File: rtl/aes_key_sched_ctrl.sv
// aes_key_sched_ctrl: AES-128 key expansion sequencer. Loads a cipher key and streams
// round keys 0..NR over a valid/ready interface, one per accepted beat.
// Optional macro AES_KEY_STORE_EN adds an 11-entry round-key store with a registered read port.
// dbg_state exposes the FSM state (0=IDLE, 1=EMIT, 2=FIN).
module aes_key_sched_ctrl #(
    parameter int NR = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    aes_key_sched_ctrl_if.slave   bus,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        FIN  = 2'd2
    } state_e;

    localparam logic [3:0] NR_L = 4'(NR);

    // AES forward S-box, byte i at bits [8*i +: 8] (byte 0 leftmost)
    localparam logic [0:2047] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TBL[{b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] rc;
        case (r)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    state_e         state_q, state_d;
    logic [0:127]   rk_out_q, rk_out_d;
    logic [3:0]     rk_round_q, rk_round_d;
    logic           rk_valid_q, rk_valid_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    logic           hs;
    logic [3:0]     rcon_round;
    logic [0:31]    w0, w1, w2, w3;
    logic [0:31]    rot_word, sub_word, t_word;
    logic [0:31]    n0, n1, n2, n3;
    logic [0:127]   next_key;

    assign hs = rk_valid_q && bus.rk_ready;

    // Round input to rcon: the round being produced, clamped so it never exceeds NR
    assign rcon_round = (rk_round_q < NR_L) ? (rk_round_q + 4'd1) : NR_L;

    assign w0 = rk_out_q[0:31];
    assign w1 = rk_out_q[32:63];
    assign w2 = rk_out_q[64:95];
    assign w3 = rk_out_q[96:127];

    assign rot_word = {w3[8:31], w3[0:7]};

    // Four byte S-box lookups forming SubWord
    for (genvar i = 0; i < 4; i++) begin : g_sbox
        assign sub_word[8*i +: 8] = sbox(rot_word[8*i +: 8]);
    end

    assign t_word   = sub_word ^ {rcon(rcon_round), 24'h000000};
    assign n0       = w0 ^ t_word;
    assign n1       = w1 ^ n0;
    assign n2       = w2 ^ n1;
    assign n3       = w3 ^ n2;
    assign next_key = {n0, n1, n2, n3};

`ifdef AES_KEY_STORE_EN
    logic [0:127]   store_q [0:10];
    logic [0:127]   rd_key_q, rd_key_d;
    logic           store_valid_q, store_valid_d;
`endif

    // Next-state, stream registers and status outputs
    always_comb begin
        state_d    = state_q;
        rk_out_d   = rk_out_q;
        rk_round_d = rk_round_q;
        rk_valid_d = rk_valid_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
`ifdef AES_KEY_STORE_EN
        store_valid_d = store_valid_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d    = EMIT;
                    rk_out_d   = bus.key_in;
                    rk_round_d = 4'd0;
                    rk_valid_d = 1'b1;
                    busy_d     = 1'b1;
`ifdef AES_KEY_STORE_EN
                    store_valid_d = 1'b0;
`endif
                end
            end
            EMIT: begin
                if (hs) begin
                    if (rk_round_q == NR_L) begin
                        state_d    = FIN;
                        rk_valid_d = 1'b0;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
`ifdef AES_KEY_STORE_EN
                        store_valid_d = 1'b1;
`endif
                    end else begin
                        rk_out_d   = next_key;
                        rk_round_d = rk_round_q + 4'd1;
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rk_out_q   <= '0;
            rk_round_q <= 4'd0;
            rk_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rk_out_q   <= rk_out_d;
            rk_round_q <= rk_round_d;
            rk_valid_q <= rk_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

`ifdef AES_KEY_STORE_EN
    // Registered read port; addresses beyond NR read as zero
    always_comb begin
        rd_key_d = '0;
        if (bus.rd_addr <= NR_L) begin
            rd_key_d = store_q[bus.rd_addr];
        end
    end

    // Store contents survive rst; store_valid tells the reader whether they are usable
    always_ff @(posedge clk) begin
        if (hs && !rst) begin
            store_q[rk_round_q] <= rk_out_q;
        end
    end

    // Read data and store-valid flag
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_key_q      <= '0;
            store_valid_q <= 1'b0;
        end else begin
            rd_key_q      <= rd_key_d;
            store_valid_q <= store_valid_d;
        end
    end

    assign bus.rd_key      = rd_key_q;
    assign bus.store_valid = store_valid_q;
`endif

    assign bus.rk_out   = rk_out_q;
    assign bus.rk_round = rk_round_q;
    assign bus.rk_valid = rk_valid_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// tb_aes_key_sched_ctrl: directed bench for aes_key_sched_ctrl (NR=10 and NR=1 instances).
// Honours AES_KEY_STORE_EN when defined at compile time.
module tb_aes_key_sched_ctrl;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    aes_key_sched_ctrl_if bus0 ();
    aes_key_sched_ctrl_if bus1 ();
    logic [1:0] dbg0, dbg1;

    aes_key_sched_ctrl #(.NR(10)) dut0 (.clk(clk), .rst(rst), .bus(bus0), .dbg_state(dbg0));
    aes_key_sched_ctrl #(.NR(1))  dut1 (.clk(clk), .rst(rst), .bus(bus1), .dbg_state(dbg1));

    int checks   = 0;
    int failures = 0;

    // FIPS-197 appendix A.1 expansion of 2b7e151628aed2a6abf7158809cf4f3c
    logic [127:0] fips_rk [11] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };
    localparam logic [127:0] ZERO_R1 = 128'h62636363626363636263636362636363;

    // ---------------- scoreboard ----------------
    logic [131:0] exp_q[$];
    logic [131:0] exp1_q[$];

    task automatic check(input string name, input logic [135:0] act, input logic [135:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    logic         stall_prev = 1'b0;
    logic [3:0]   prev_round;
    logic [127:0] prev_key;
    logic [131:0] item;

    // Monitor for the NR=10 instance
    always @(negedge clk) begin
        if (!rst) begin
            if (stall_prev)
                check("stall_hold", {bus0.rk_valid, bus0.rk_round, bus0.rk_out},
                      {1'b1, prev_round, prev_key});
            if (bus0.rk_valid && bus0.rk_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat actual round=%0d key=%h required no beat",
                             bus0.rk_round, bus0.rk_out);
                end else begin
                    item = exp_q.pop_front();
                    check("beat0", {bus0.rk_round, bus0.rk_out}, item);
                end
                check("rcon_bound0", (dut0.rcon_round <= 4'd10), 1);
            end
            if (bus0.done) check("done_excl0", bus0.rk_valid, 0);
        end
        stall_prev = bus0.rk_valid && !bus0.rk_ready && !rst;
        prev_round = bus0.rk_round;
        prev_key   = bus0.rk_out;
    end

    // Monitor for the NR=1 instance
    always @(negedge clk) begin
        if (!rst && bus1.rk_valid) begin
            check("rcon_bound1", (dut1.rcon_round <= 4'd1), 1);
            if (bus1.rk_ready) begin
                if (exp1_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat1 actual round=%0d required no beat", bus1.rk_round);
                end else begin
                    item = exp1_q.pop_front();
                    check("beat1", {bus1.rk_round, bus1.rk_out}, item);
                end
            end
        end
    end

    // ---------------- driver ----------------
    logic rand_mode = 1'b0;
    always @(posedge clk) begin
        if (rand_mode) begin
            #1 bus0.rk_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_fips(input int last);
        for (int r = 0; r <= last; r++) exp_q.push_back({4'(r), fips_rk[r]});
    endtask

    task automatic start_key(input bit sel, input logic [127:0] key);
        if (sel) begin bus1.start = 1'b1; bus1.key_in = key; end
        else     begin bus0.start = 1'b1; bus0.key_in = key; end
        tick();
        bus0.start = 1'b0;
        bus1.start = 1'b0;
    endtask

    task automatic wait_done(input bit sel, input int max, output int cycles, output bit seen);
        cycles = 1;
        while (!(sel ? bus1.done : bus0.done) && cycles < max) begin
            tick();
            cycles++;
        end
        seen = sel ? bus1.done : bus0.done;
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL done_timeout actual=no done required done within %0d cycles", max);
        end
    endtask

    task automatic wait_round(input logic [3:0] r, input int max);
        int n = 0;
        while (bus0.rk_round != r && n < max) begin
            tick();
            n++;
        end
        check("reach_round", bus0.rk_round, r);
    endtask

    int cyc;
    bit seen;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        bus0.start = 1'b0; bus0.key_in = '0; bus0.rk_ready = 1'b1;
        bus1.start = 1'b0; bus1.key_in = '0; bus1.rk_ready = 1'b1;
`ifdef AES_KEY_STORE_EN
        bus0.rd_addr = '0;
        bus1.rd_addr = '0;
`endif
        repeat (2) tick();
        check("rst_status0", {bus0.busy, bus0.rk_valid, bus0.done, dbg0}, 0);
        check("rst_round0", bus0.rk_round, 0);
        check("rst_key0", bus0.rk_out, 0);
        check("rst_status1", {bus1.busy, bus1.rk_valid, bus1.done, dbg1}, 0);
        rst = 1'b0;
        tick();

        // FIPS key, rk_ready held high
        push_fips(10);
        start_key(1'b0, fips_rk[0]);
        check("busy_after_start", bus0.busy, 1);
        wait_done(1'b0, 40, cyc, seen);
        check("done_latency", cyc, 12);
        check("fin_state", dbg0, 2);
        check("q_empty_fips", exp_q.size(), 0);
        // start during FIN is ignored
        start_key(1'b0, 128'h00112233445566778899aabbccddeeff);
        check("fin_start_ignored", {bus0.busy, bus0.rk_valid, bus0.done, dbg0}, 0);
        tick();
        check("fin_start_idle", {bus0.busy, bus0.rk_valid}, 0);
`ifdef AES_KEY_STORE_EN
        bus0.rd_addr = 4'd10;
        tick();
        check("store_rd10", bus0.rd_key, fips_rk[10]);
        check("store_valid_set", bus0.store_valid, 1);
        bus0.rd_addr = 4'd3;
        tick();
        check("store_rd3", bus0.rd_key, fips_rk[3]);
        bus0.rd_addr = 4'd11;
        tick();
        check("store_rd_oob", bus0.rd_key, 0);
`endif

        // Same key with pseudo-random backpressure
        push_fips(10);
        rand_mode = 1'b1;
        start_key(1'b0, fips_rk[0]);
`ifdef AES_KEY_STORE_EN
        check("store_valid_clr", bus0.store_valid, 0);
`endif
        wait_done(1'b0, 400, cyc, seen);
        rand_mode = 1'b0;
        bus0.rk_ready = 1'b1;
        check("q_empty_bp", exp_q.size(), 0);
        repeat (2) tick();

        // start pulsed mid-stream with a different key
        push_fips(10);
        start_key(1'b0, fips_rk[0]);
        wait_round(4'd4, 20);
        bus0.start = 1'b1;
        bus0.key_in = 128'hffeeddccbbaa99887766554433221100;
        tick();
        bus0.start = 1'b0;
        wait_done(1'b0, 40, cyc, seen);
        check("q_empty_midstart", exp_q.size(), 0);
        repeat (2) tick();

        // rst at round 6
        push_fips(5);
        start_key(1'b0, fips_rk[0]);
        wait_round(4'd6, 20);
        bus0.rk_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus0.rk_ready = 1'b1;
        check("midrst_status", {bus0.busy, bus0.rk_valid, bus0.done, dbg0}, 0);
        check("midrst_key", bus0.rk_out, 0);
        check("midrst_round", bus0.rk_round, 0);
        repeat (3) begin
            tick();
            check("midrst_no_done", bus0.done, 0);
        end
        check("q_empty_rst", exp_q.size(), 0);

        // all-zero key after reset, first two rounds, then abort
        exp_q.push_back({4'd0, 128'h0});
        exp_q.push_back({4'd1, ZERO_R1});
        start_key(1'b0, 128'h0);
        wait_round(4'd2, 20);
        bus0.rk_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus0.rk_ready = 1'b1;
        check("q_empty_zero", exp_q.size(), 0);
        tick();

        // NR=1 instance: two beats then done
        exp1_q.push_back({4'd0, fips_rk[0]});
        exp1_q.push_back({4'd1, fips_rk[1]});
        start_key(1'b1, fips_rk[0]);
        wait_done(1'b1, 20, cyc, seen);
        check("nr1_latency", cyc, 3);
        check("q_empty_nr1", exp1_q.size(), 0);
        repeat (2) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
